// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: DMEM req/ack, lane steering, load extension, timeout.
// Optional MEM_STAGE_PERF_EN adds saturating load/store/stall-cycle counters.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        FLUSH_IN,
  input  logic        Valid_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] StoreData_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        WriteEnable_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [1:0]  MemSize_IN,
  input  logic        MemSigned_IN,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [31:0] WriteData_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        WriteEnable_OUT,
  output logic        STALL_OUT,
  output logic        Misaligned_OUT,
  output logic        BusError_OUT
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] LoadCount_OUT,
  output logic [31:0] StoreCount_OUT,
  output logic [31:0] StallCycles_OUT
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state, stateNext;
  logic [CW-1:0] timeoutCount;
  logic [31:0]   loadBuffer;
  logic          kill, killNext;
  logic          busErrorNext;
  logic          memOp, misaligned, startOp, timeoutHit;
  logic [1:0]    lane;
  logic [31:0]   laneWord, loadData;

  assign lane    = ALUResult_IN[1:0];
  assign memOp   = Valid_IN & (MemRead_IN | MemWrite_IN);
  assign startOp = memOp & ~misaligned & ~FLUSH_IN;

  always_comb begin
    case (MemSize_IN)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      default: misaligned = |lane;
    endcase
  end

  assign Misaligned_OUT = memOp & misaligned;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeoutHit = (timeoutCount == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeoutHit = 1'b0;
    end
  endgenerate

  // Address, enables and data come straight from EXE/MEM, which the stall holds stable.
  assign DMEM_ADDR = {ALUResult_IN[31:2], 2'b00};
  assign DMEM_WE   = DMEM_REQ & MemWrite_IN;

  always_comb begin
    case (MemSize_IN)
      2'b00: begin
        DMEM_BE    = 4'b0001 << lane;
        DMEM_WDATA = {4{StoreData_IN[7:0]}};
      end
      2'b01: begin
        DMEM_BE    = lane[1] ? 4'b1100 : 4'b0011;
        DMEM_WDATA = {2{StoreData_IN[15:0]}};
      end
      default: begin
        DMEM_BE    = 4'b1111;
        DMEM_WDATA = StoreData_IN;
      end
    endcase
  end

  assign laneWord = loadBuffer >> {lane, 3'b000};

  always_comb begin
    case (MemSize_IN)
      2'b00:   loadData = {{24{MemSigned_IN & laneWord[7]}}, laneWord[7:0]};
      2'b01:   loadData = {{16{MemSigned_IN & laneWord[15]}}, laneWord[15:0]};
      default: loadData = loadBuffer;
    endcase
  end

  always_comb begin
    stateNext         = state;
    killNext          = kill;
    busErrorNext      = 1'b0;
    DMEM_REQ          = 1'b0;
    STALL_OUT         = 1'b0;
    WriteData_OUT     = Valid_IN ? ALUResult_IN : 32'd0;
    WriteRegister_OUT = Valid_IN ? WriteRegister_IN : 5'd0;
    WriteEnable_OUT   = 1'b0;
    case (state)
      IDLE: begin
        if (startOp) begin
          STALL_OUT = 1'b1;
          stateNext = BUSY;
        end else begin
          WriteEnable_OUT = Valid_IN & WriteEnable_IN & ~FLUSH_IN & ~Misaligned_OUT;
        end
      end
      BUSY: begin
        // A flush only poisons write-back; the bus transaction must still complete.
        DMEM_REQ  = 1'b1;
        STALL_OUT = 1'b1;
        if (FLUSH_IN) killNext = 1'b1;
        if (DMEM_ACK) begin
          stateNext = DONE;
        end else if (timeoutHit) begin
          stateNext    = DONE;
          killNext     = 1'b1;
          busErrorNext = 1'b1;
        end
      end
      DONE: begin
        if (MemRead_IN) WriteData_OUT = loadData;
        WriteEnable_OUT = WriteEnable_IN & ~kill & ~FLUSH_IN;
        stateNext       = IDLE;
        killNext        = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
    if (RESET) begin
      DMEM_REQ  = 1'b0;
      STALL_OUT = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      timeoutCount <= '0;
      loadBuffer   <= 32'd0;
      kill         <= 1'b0;
      BusError_OUT <= 1'b0;
    end else begin
      state        <= stateNext;
      kill         <= killNext;
      BusError_OUT <= busErrorNext;
      if (state == BUSY && DMEM_ACK) loadBuffer <= DMEM_RDATA;
      if (state == BUSY) timeoutCount <= timeoutCount + CW'(1);
      else               timeoutCount <= '0;
    end
  end

`ifdef MEM_STAGE_PERF_EN
  logic retire;
  assign retire = (state == DONE) & ~kill & ~FLUSH_IN;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      LoadCount_OUT   <= 32'd0;
      StoreCount_OUT  <= 32'd0;
      StallCycles_OUT <= 32'd0;
    end else begin
      if (retire && MemRead_IN && LoadCount_OUT != 32'hFFFF_FFFF)
        LoadCount_OUT <= LoadCount_OUT + 32'd1;
      if (retire && MemWrite_IN && StoreCount_OUT != 32'hFFFF_FFFF)
        StoreCount_OUT <= StoreCount_OUT + 32'd1;
      if (STALL_OUT && StallCycles_OUT != 32'hFFFF_FFFF)
        StallCycles_OUT <= StallCycles_OUT + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage between the EXE/MEM and MEM/WB pipeline registers. Loads and stores go to an external data memory over a req/ack handshake. The block produces the write-back triple (data, register, enable) that MEM/WB captures, and raises a stall to the hazard unit while a memory transaction is outstanding. It also handles byte/halfword lane steering, load extension and misalignment detection.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in BUSY without DMEM_ACK before the transaction is abandoned as a bus error; 0 disables the timeout.

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
FLUSH_IN  in  1  kill the current MEM-stage instruction (from hazard unit)
Valid_IN  in  1  EXE/MEM holds a valid instruction
ALUResult_IN  in  32  effective address / ALU result
StoreData_IN  in  32  rt value for stores
WriteRegister_IN  in  5  destination register
WriteEnable_IN  in  1  instruction writes the register file
MemRead_IN  in  1  load
MemWrite_IN  in  1  store
MemSize_IN  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
MemSigned_IN  in  1  sign-extend loads when 1
DMEM_REQ  out  1  memory request
DMEM_WE  out  1  write strobe, qualified by DMEM_REQ
DMEM_ADDR  out  32  word address; {ALUResult_IN[31:2],2'b00}
DMEM_BE  out  4  byte enables
DMEM_WDATA  out  32  lane-replicated store data
DMEM_RDATA  in  32  read data, valid with DMEM_ACK
DMEM_ACK  in  1  one-cycle completion pulse
WriteData_OUT  out  32  to MEM/WB
WriteRegister_OUT  out  5  to MEM/WB
WriteEnable_OUT  out  1  to MEM/WB
STALL_OUT  out  1  stall EXE/MEM and earlier stages, and hold MEM/WB
Misaligned_OUT  out  1  misaligned access flag (combinational)
BusError_OUT  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset: state IDLE; timeout counter 0; load buffer 0; kill flag 0; BusError_OUT 0. DMEM_REQ drops immediately on RESET, including mid-transaction. Any outstanding ACK arriving after reset is ignored.
- Misalignment:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - A misaligned memory op issues no request and raises no stall.
  - Misaligned_OUT=1 and WriteEnable_OUT=0 in that cycle.
- Non-memory op, or Valid_IN=0:
  - Purely combinational pass-through, zero latency.
  - WriteData_OUT=ALUResult_IN; register and enable pass through; enable is gated by Valid_IN and !FLUSH_IN.
  - STALL_OUT=0.
  - With Valid_IN=0, all write-back outputs are 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: a valid, aligned mem op with FLUSH_IN=0 sets STALL_OUT=1 and moves to BUSY next edge. FLUSH_IN=1 here means no request is issued.
  - BUSY:
    - DMEM_REQ=1 and STALL_OUT=1; DMEM_WE=MemWrite_IN; address, BE and WDATA are held stable.
    - On DMEM_ACK: capture DMEM_RDATA into the load buffer and go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 with no ACK: pulse BusError_OUT, set kill, go to DONE.
    - FLUSH_IN=1 in BUSY sets kill but never aborts the bus transaction.
  - DONE:
    - STALL_OUT=0. WriteData_OUT=extended load data for loads, ALUResult_IN for stores.
    - WriteEnable_OUT=WriteEnable_IN & !kill & !FLUSH_IN.
    - Next edge: IDLE, with kill and the counter cleared.
- Minimum memory-op occupancy is 3 cycles: IDLE, then BUSY with ACK in that same cycle, then DONE.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1]?1100:0011
  - word: 1111
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extraction: lane selected by addr[1:0], zero- or sign-extended per MemSigned_IN.
- DMEM_ACK outside BUSY is ignored.

Optional Feature:
MEM_STAGE_PERF_EN: adds output ports LoadCount_OUT[31:0], StoreCount_OUT[31:0] and StallCycles_OUT[31:0].
- LoadCount_OUT / StoreCount_OUT count completed, non-killed loads and stores (counted in DONE).
- StallCycles_OUT counts cycles with STALL_OUT=1.
- All three saturate at 0xFFFFFFFF and are cleared by RESET.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ALU op, ALUResult_IN=0x00001234, WriteRegister_IN=5, WriteEnable_IN=1 -> same cycle WriteData_OUT=0x00001234, WriteRegister_OUT=5, WriteEnable_OUT=1, STALL_OUT=0, DMEM_REQ=0.
- Signed byte load from 0x103, RDATA=0x80FF7F01, ACK 2 cycles after REQ -> DMEM_ADDR=0x100, BE=1000, STALL_OUT=1 for 4 cycles, then DONE WriteData_OUT=0xFFFFFF80; with MemSigned_IN=0 -> 0x00000080.
- Half store of 0x0000ABCD to 0x202 -> DMEM_WE=1, BE=1100, WDATA=0xABCDABCD, WriteEnable_OUT=0; word load from 0x202 -> Misaligned_OUT=1, no REQ, STALL_OUT=0.
- Word load with no ACK, TIMEOUT_CYCLES=4 -> REQ high for 4 cycles, BusError_OUT one-cycle pulse, DONE with WriteEnable_OUT=0, return to IDLE.
- FLUSH_IN pulsed in BUSY, ACK later -> REQ stays high until ACK, DONE WriteEnable_OUT=0; RESET asserted in BUSY -> DMEM_REQ=0 immediately, STALL_OUT=0, state IDLE.
